mp5_phantom_map: RTL and testbench
==================================

MP5_PHANTOM_MAP -- requirements
Module: mp5_phantom_map

Interface
REQ-001 Parameters SHALL be:
  - NUM_PIPELINES, default 2, number of pipelines/FIFOs per stage.
  - FIFO_SIZE, default 8, depth of each stage FIFO.
  - MAP_DEPTH, default 16, number of phantom-map entries.
  - TIMEOUT, default 200, entry lifetime in cycles (range 1..255).
REQ-002 Ports SHALL be as follows (FW = $clog2(NUM_PIPELINES), AW = $clog2(FIFO_SIZE)):
  - clk  in  1  clock.
  - rst  in  1  reset; synchronous, active-high; clock clk.
  - in_valid  in  1  packet arriving for the downstream stage.
  - in_pkt  in  Packet  arriving packet.
  - in_fifo_id  in  FW  target FIFO of the arriving packet.
  - rec_valid  in  1  stage reports that a phantom was enqueued.
  - rec_id  in  16  phantom id (stage pkt_id_out).
  - rec_addr  in  AW  FIFO slot of the phantom (stage pkt_addr_out).
  - rec_fifo_id  in  FW  FIFO holding the phantom.
  - out_push  out  1  drives stage push_in.
  - out_insert  out  1  drives stage insert_in.
  - out_addr  out  AW  drives stage addr_in.
  - out_fifo_id  out  FW  drives stage fifo_id_in.
  - out_pkt  out  Packet  drives stage pkt_in.
  - occupancy  out  $clog2(MAP_DEPTH)+1  number of valid entries.
  - drop_cnt  out  16  records lost because the map was full.
  - timeout_cnt  out  16  entries expired by timeout.

Function
REQ-003 Each entry SHALL hold valid, id[15:0], fifo_id[FW], addr[AW], age[7:0].
REQ-004 Outputs SHALL be registered, with latency exactly 1 cycle from in_valid to out_push/out_insert.
REQ-005 When in_valid=1 and in_pkt.is_phantom=1, the next cycle SHALL give out_push=1, out_pkt=in_pkt, out_fifo_id=in_fifo_id, out_insert=0.
REQ-006 When in_valid=1, is_phantom=0, and a valid entry has id==in_pkt.id, the next cycle SHALL give out_insert=1, out_push=0, out_addr=entry.addr, out_fifo_id=entry.fifo_id, out_pkt=in_pkt; that entry SHALL be invalidated.
REQ-007 When in_valid=1, is_phantom=0, and no entry matches, the block SHALL behave as in REQ-005 (plain push).
REQ-008 out_push and out_insert SHALL never both be 1; both SHALL be 0 in any cycle following in_valid=0.
REQ-009 Recording (rec_valid=1): if a valid entry has id==rec_id, that entry SHALL be overwritten and its age cleared; otherwise the lowest-index invalid entry SHALL be written with age=0.
REQ-010 When rec_valid=1 with no match and no free entry, the record SHALL be dropped and drop_cnt SHALL increment.
REQ-011 Lookup SHALL see only entries valid at the start of the cycle: a record and a lookup of the same id in the same cycle SHALL yield a push, with the record stored.
REQ-012 Age of each valid entry SHALL increment every cycle; an entry reaching age==TIMEOUT SHALL be invalidated and timeout_cnt SHALL increment by the number expiring that cycle.
REQ-013 A match and a timeout on the same entry in the same cycle SHALL resolve as a match (insert); timeout_cnt SHALL not increment.
REQ-014 A record and a lookup match in the same cycle on different entries SHALL both take effect.
REQ-015 Free-slot selection SHALL use the valid bits at the start of the cycle; slots freed in the current cycle SHALL not be reused until the next cycle.
REQ-016 drop_cnt and timeout_cnt SHALL saturate at 16'hFFFF.
REQ-017 occupancy SHALL equal the popcount of the valid bits, registered.
REQ-018 Multiple entries sharing an id SHALL be impossible by construction (REQ-009).

Reset
REQ-019 On rst=1 at a clk edge, all valid bits, out_push, out_insert, out_addr, out_fifo_id, out_pkt, occupancy, drop_cnt and timeout_cnt SHALL become 0.
REQ-020 Reset asserted mid-operation SHALL discard all entries, including in-flight inputs of that cycle.

Structure
REQ-021 NUM_PIPELINES, FIFO_SIZE and the Packet typedef SHALL reside in a shared package mp5_pkg, used by this block and the stage.
REQ-022 The map entry typedef SHALL be local to this block.
REQ-023 One sub-module, mp5_prio_enc (lowest-index free-slot encoder), SHALL be used.

Verification
REQ-024 Record id=5, addr=3, fifo=1; next cycle send a non-phantom with id=5 -> one cycle later out_insert=1, out_addr=3, out_fifo_id=1, occupancy 1->0.
REQ-025 Send a non-phantom with id=9 into an empty map -> out_push=1, out_insert=0, out_fifo_id=in_fifo_id.
REQ-026 Issue 17 distinct records with MAP_DEPTH=16 -> occupancy=16, drop_cnt=1.
REQ-027 Record id=7, then idle for TIMEOUT cycles -> entry gone, timeout_cnt=1; a later id=7 lookup pushes.
REQ-028 Record id=4 and look up id=4 in the same cycle -> push; a lookup of id=4 the following cycle -> insert.
REQ-029 Assert rst with 3 valid entries -> occupancy=0 and both counters 0 the next cycle; a lookup of a formerly recorded id pushes.

Source files
------------

// File: rtl/mp5_pkg.sv
// Types and sizes shared by the phantom map and the pipeline stage it drives.
package mp5_pkg;

    localparam int NUM_PIPELINES = 2;
    localparam int FIFO_SIZE     = 8;

    typedef struct packed {
        logic        is_phantom;
        logic [15:0] id;
        logic [31:0] data;
    } Packet;

endpackage

// File: rtl/mp5_prio_enc.sv
// Lowest-index priority encoder: reports whether any request bit is set and which one wins.
module mp5_prio_enc #(
    parameter  int N = 16,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/mp5_phantom_map.sv
// Remembers where phantom packets were enqueued and turns the matching real packet
// into an in-place insert at that FIFO slot; unmatched packets are plain pushes.
module mp5_phantom_map #(
    parameter  int NUM_PIPELINES = mp5_pkg::NUM_PIPELINES,
    parameter  int FIFO_SIZE     = mp5_pkg::FIFO_SIZE,
    parameter  int MAP_DEPTH     = 16,
    parameter  int TIMEOUT       = 200,
    localparam int FW = (NUM_PIPELINES > 1) ? $clog2(NUM_PIPELINES) : 1,
    localparam int AW = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1,
    localparam int IW = (MAP_DEPTH > 1) ? $clog2(MAP_DEPTH) : 1,
    localparam int OW = $clog2(MAP_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  mp5_pkg::Packet in_pkt,
    input  logic [FW-1:0] in_fifo_id,
    input  logic          rec_valid,
    input  logic [15:0]   rec_id,
    input  logic [AW-1:0] rec_addr,
    input  logic [FW-1:0] rec_fifo_id,
    output logic          out_push,
    output logic          out_insert,
    output logic [AW-1:0] out_addr,
    output logic [FW-1:0] out_fifo_id,
    output mp5_pkg::Packet out_pkt,
    output logic [OW-1:0] occupancy,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   timeout_cnt
);

    typedef struct packed {
        logic          valid;
        logic [15:0]   id;
        logic [FW-1:0] fifo_id;
        logic [AW-1:0] addr;
        logic [7:0]    age;
    } entry_t;

    entry_t [MAP_DEPTH-1:0] map_q, map_d;

    logic           push_q, insert_q;
    logic [AW-1:0]  addr_q;
    logic [FW-1:0]  fifo_q;
    mp5_pkg::Packet pkt_q;
    logic [OW-1:0]  occ_q, occ_d;
    logic [15:0]    drop_q, tmo_q;
    logic [16:0]    tmo_sum;
    logic [OW-1:0]  n_exp;

    logic [MAP_DEPTH-1:0] free_vec, lk_hit, rec_hit;
    logic                 free_found, lk_found, rec_found, lk_do, drop;
    logic [IW-1:0]        free_idx, lk_idx, rec_idx;

    always_comb begin
        for (int i = 0; i < MAP_DEPTH; i++) begin
            free_vec[i] = !map_q[i].valid;
            lk_hit[i]   = map_q[i].valid && (map_q[i].id == in_pkt.id);
            rec_hit[i]  = map_q[i].valid && (map_q[i].id == rec_id);
        end
    end

    mp5_prio_enc #(.N(MAP_DEPTH)) u_free (.req_i(free_vec), .found_o(free_found), .idx_o(free_idx));
    mp5_prio_enc #(.N(MAP_DEPTH)) u_lk   (.req_i(lk_hit),   .found_o(lk_found),   .idx_o(lk_idx));
    mp5_prio_enc #(.N(MAP_DEPTH)) u_rec  (.req_i(rec_hit),  .found_o(rec_found),  .idx_o(rec_idx));

    assign lk_do = in_valid && !in_pkt.is_phantom && lk_found;
    assign drop  = rec_valid && !rec_found && !free_found;

    always_comb begin
        map_d = map_q;
        n_exp = '0;
        for (int i = 0; i < MAP_DEPTH; i++) begin
            if (map_q[i].valid) begin
                map_d[i].age = map_q[i].age + 8'd1;
                // A lookup hit beats expiry; an entry about to be rewritten is not counted as expired.
                if (lk_do && lk_hit[i]) begin
                    map_d[i].valid = 1'b0;
                end else if (map_q[i].age == 8'(TIMEOUT - 1)) begin
                    map_d[i].valid = 1'b0;
                    if (!(rec_valid && rec_hit[i])) n_exp = n_exp + OW'(1);
                end
            end
        end
        if (rec_valid && (rec_found || free_found)) begin
            map_d[rec_found ? rec_idx : free_idx] = '{valid: 1'b1, id: rec_id,
                fifo_id: rec_fifo_id, addr: rec_addr, age: 8'd0};
        end
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < MAP_DEPTH; i++) occ_d = occ_d + OW'(map_d[i].valid);
    end

    assign tmo_sum = {1'b0, tmo_q} + 17'(n_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            map_q    <= '0;
            push_q   <= 1'b0;
            insert_q <= 1'b0;
            addr_q   <= '0;
            fifo_q   <= '0;
            pkt_q    <= '0;
            occ_q    <= '0;
            drop_q   <= '0;
            tmo_q    <= '0;
        end else begin
            map_q    <= map_d;
            push_q   <= in_valid && !lk_do;
            insert_q <= lk_do;
            if (in_valid) begin
                pkt_q  <= in_pkt;
                fifo_q <= lk_do ? map_q[lk_idx].fifo_id : in_fifo_id;
                if (lk_do) addr_q <= map_q[lk_idx].addr;
            end
            occ_q <= occ_d;
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            tmo_q <= tmo_sum[16] ? 16'hFFFF : tmo_sum[15:0];
        end
    end

    assign out_push    = push_q;
    assign out_insert  = insert_q;
    assign out_addr    = addr_q;
    assign out_fifo_id = fifo_q;
    assign out_pkt     = pkt_q;
    assign occupancy   = occ_q;
    assign drop_cnt    = drop_q;
    assign timeout_cnt = tmo_q;

endmodule

// File: tb/tb_mp5_phantom_map.sv
// Directed bench: expected stage commands are queued when a packet is driven and
// checked one cycle later; map counters are checked against hand-derived values.
module tb_mp5_phantom_map;

    localparam int FW = 1;
    localparam int AW = 3;
    localparam int T  = 200;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    mp5_pkg::Packet in_pkt;
    logic [FW-1:0]  in_fifo_id;
    logic           rec_valid;
    logic [15:0]    rec_id;
    logic [AW-1:0]  rec_addr;
    logic [FW-1:0]  rec_fifo_id;
    logic           out_push, out_insert;
    logic [AW-1:0]  out_addr;
    logic [FW-1:0]  out_fifo_id;
    mp5_pkg::Packet out_pkt;
    logic [4:0]     occupancy;
    logic [15:0]    drop_cnt, timeout_cnt;

    mp5_phantom_map #(.MAP_DEPTH(16), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pkt(in_pkt), .in_fifo_id(in_fifo_id),
        .rec_valid(rec_valid), .rec_id(rec_id), .rec_addr(rec_addr), .rec_fifo_id(rec_fifo_id),
        .out_push(out_push), .out_insert(out_insert), .out_addr(out_addr),
        .out_fifo_id(out_fifo_id), .out_pkt(out_pkt), .occupancy(occupancy),
        .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           ins;
        logic [AW-1:0]  addr;
        logic [FW-1:0]  fid;
        mp5_pkg::Packet pkt;
    } exp_t;

    exp_t sbq[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample #1 later, compare against the scoreboard, then clear strobes.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("push",    64'(out_push),    64'(!e.ins));
            chk("insert",  64'(out_insert),  64'(e.ins));
            chk("fifo_id", 64'(out_fifo_id), 64'(e.fid));
            chk("pkt",     64'(out_pkt),     64'(e.pkt));
            if (e.ins) chk("addr", 64'(out_addr), 64'(e.addr));
        end else begin
            chk("idle_push",   64'(out_push),   64'd0);
            chk("idle_insert", 64'(out_insert), 64'd0);
        end
        in_valid  = 1'b0;
        rec_valid = 1'b0;
    endtask

    task automatic send(input logic ph, input logic [15:0] id, input logic [FW-1:0] fid,
                        input logic ins, input logic [AW-1:0] ea, input logic [FW-1:0] ef);
        exp_t e;
        in_valid   = 1'b1;
        in_pkt     = '{is_phantom: ph, id: id, data: $urandom};
        in_fifo_id = fid;
        e.ins  = ins;
        e.addr = ea;
        e.fid  = ins ? ef : fid;
        e.pkt  = in_pkt;
        sbq.push_back(e);
    endtask

    task automatic rec(input logic [15:0] id, input logic [AW-1:0] a, input logic [FW-1:0] f);
        rec_valid   = 1'b1;
        rec_id      = id;
        rec_addr    = a;
        rec_fifo_id = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pkt = '0; in_fifo_id = '0;
        rec_valid = 1'b0; rec_id = '0; rec_addr = '0; rec_fifo_id = '0;
        idle(2);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_tmo", 64'(timeout_cnt), 64'd0);
        rst = 1'b0;
        idle(1);

        // Empty map: real packet and phantom packet are both plain pushes.
        send(1'b0, 16'd9, 1'b1, 1'b0, '0, '0); tick();
        send(1'b1, 16'd3, 1'b0, 1'b0, '0, '0); tick();

        // Record then match -> insert at recorded slot.
        rec(16'd5, 3'd3, 1'b1); tick();
        chk("occ_after_rec5", 64'(occupancy), 64'd1);
        send(1'b0, 16'd5, 1'b0, 1'b1, 3'd3, 1'b1); tick();
        chk("occ_after_ins5", 64'(occupancy), 64'd0);

        // Same-cycle record and lookup: lookup misses, record lands; next lookup hits.
        rec(16'd4, 3'd2, 1'b0); send(1'b0, 16'd4, 1'b1, 1'b0, '0, '0); tick();
        send(1'b0, 16'd4, 1'b1, 1'b1, 3'd2, 1'b0); tick();
        chk("occ_after_ins4", 64'(occupancy), 64'd0);

        // Timeout: entry lives T cycles after recording.
        rec(16'd7, 3'd1, 1'b1); tick();
        idle(T - 1);
        chk("occ_before_exp", 64'(occupancy), 64'd1);
        idle(1);
        chk("occ_after_exp", 64'(occupancy), 64'd0);
        chk("tmo_one", 64'(timeout_cnt), 64'd1);
        send(1'b0, 16'd7, 1'b0, 1'b0, '0, '0); tick();

        // Lookup on the expiry cycle resolves as a match; no timeout counted.
        rec(16'd50, 3'd6, 1'b0); tick();
        idle(T - 1);
        send(1'b0, 16'd50, 1'b1, 1'b1, 3'd6, 1'b0); tick();
        chk("tmo_match_wins", 64'(timeout_cnt), 64'd1);
        chk("occ_match_wins", 64'(occupancy), 64'd0);

        // Fill: 17 distinct records into 16 entries.
        for (int i = 0; i < 17; i++) begin
            rec(16'(100 + i), AW'(i % 8), FW'(i % 2)); tick();
        end
        chk("occ_full", 64'(occupancy), 64'd16);
        chk("drop_one", 64'(drop_cnt), 64'd1);
        send(1'b0, 16'd100, 1'b0, 1'b1, 3'd0, 1'b0); tick();
        chk("occ_15", 64'(occupancy), 64'd15);

        // Record into the one free slot while a lookup frees another: both apply.
        rec(16'd200, 3'd5, 1'b1); send(1'b0, 16'd101, 1'b0, 1'b1, 3'd1, 1'b1); tick();
        chk("occ_rec_and_hit", 64'(occupancy), 64'd15);
        rec(16'd201, 3'd4, 1'b0); tick();
        chk("occ_refull", 64'(occupancy), 64'd16);

        // Full map: a slot freed this cycle is not reusable by this cycle's record.
        rec(16'd202, 3'd2, 1'b1); send(1'b0, 16'd102, 1'b1, 1'b1, 3'd2, 1'b0); tick();
        chk("drop_two", 64'(drop_cnt), 64'd2);
        chk("occ_no_reuse", 64'(occupancy), 64'd15);

        // Re-recording an existing id overwrites in place.
        rec(16'd103, 3'd7, 1'b0); tick();
        chk("occ_overwrite", 64'(occupancy), 64'd15);
        send(1'b0, 16'd103, 1'b1, 1'b1, 3'd7, 1'b0); tick();

        // Mid-operation reset discards entries and the in-flight lookup.
        rst = 1'b1;
        in_valid = 1'b1; in_pkt = '{is_phantom: 1'b0, id: 16'd104, data: 32'h0}; in_fifo_id = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_occ", 64'(occupancy), 64'd0);
        chk("rst2_drop", 64'(drop_cnt), 64'd0);
        chk("rst2_tmo", 64'(timeout_cnt), 64'd0);
        send(1'b0, 16'd104, 1'b1, 1'b0, '0, '0); tick();
        idle(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
